// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage enables,
// decode/exec flushes, exec forwarding selects, memory freeze and stall counter.
module pipeline_ctrl #(
   parameter int RA_W    = 4,
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RA_W-1:0]  idRa,
   input  logic [RA_W-1:0]  idRb,
   input  logic             idUsesA,
   input  logic             idUsesB,
   input  logic [RA_W-1:0]  exRc,
   input  logic             exRegWrite,
   input  logic             exMemToReg,
   input  logic             exBranchTaken,
   input  logic             memReq,
   output logic             enF,
   output logic             enD,
   output logic             enE,
   output logic             enM,
   output logic             enW,
   output logic             flushD,
   output logic             flushE,
   output logic             Fa,
   output logic             Fb,
   output logic [CNT_W-1:0] stallCount
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_q, fa_d;
   logic             fb_q, fb_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             load_use;
   logic             fwd_a;
   logic             fwd_b;

   assign load_use = exMemToReg & exRegWrite &
                     ((idUsesA & (idRa == exRc)) | (idUsesB & (idRb == exRc)));
   assign fwd_a = idUsesA & exRegWrite & ~exMemToReg & (idRa == exRc);
   assign fwd_b = idUsesB & exRegWrite & ~exMemToReg & (idRb == exRc);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      enF     = 1'b0;
      enD     = 1'b0;
      enE     = 1'b0;
      enM     = 1'b0;
      enW     = 1'b0;
      flushD  = 1'b0;
      flushE  = 1'b0;
      case (state_q)
         ST_INIT: begin
            flushD  = 1'b1;
            flushE  = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            enF = 1'b1;
            enD = 1'b1;
            enE = 1'b1;
            enM = 1'b1;
            enW = 1'b1;
            // enables stay high on the request cycle so the access starts
            if (memReq && (MEM_LAT > 0)) begin
               state_d = ST_WAIT;
               cnt_d   = CW'(MEM_LAT);
            end else if (exBranchTaken) begin
               flushD = 1'b1;
               flushE = 1'b1;
            end else if (load_use) begin
               enF    = 1'b0;
               enD    = 1'b0;
               flushE = 1'b1;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            flushD  = 1'b1;
            flushE  = 1'b1;
            state_d = ST_INIT;
         end
      endcase
   end

   always_comb begin
      fa_d = fa_q;
      fb_d = fb_q;
      if (flushE) begin
         fa_d = 1'b0;
         fb_d = 1'b0;
      end else if (enE) begin
         fa_d = fwd_a;
         fb_d = fwd_b;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (((state_q == ST_RUN) || (state_q == ST_WAIT)) && !enD && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         fa_q    <= 1'b0;
         fb_q    <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         stall_q <= stall_d;
      end
   end

   assign Fa         = fa_q;
   assign Fb         = fb_q;
   assign stallCount = stall_q;

endmodule
